// File: rtl/mesa_tx_arbiter_pkg.sv
// Shared definitions for the MESA transmit arbiter: FSM state encodings,
// the legal requester-count range and an index-width helper.
package mesa_tx_arbiter_pkg;

    // Legal range for the number of byte-stream sources sharing the link.
    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 4;

    // Arbiter FSM: wait for a request, hold one packet, let the converter finish.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

    // Width of a source index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mesa_tx_arbiter_if.sv
// Byte-stream bus between the sources, the arbiter and the byte->ASCII
// converter. The arbiter takes the slave view; sources and the converter
// model take the master view.
interface mesa_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    // Source side
    logic [N_REQ-1:0]   req_vec;
    logic [N_REQ-1:0]   gnt_vec;
    logic [8*N_REQ-1:0] req_byte_d;
    logic [N_REQ-1:0]   req_byte_en;
    logic [N_REQ-1:0]   req_byte_done;
    logic [N_REQ-1:0]   req_byte_busy;
    // Converter side
    logic [7:0]         tx_byte_d;
    logic               tx_byte_en;
    logic               tx_byte_done;
    logic               tx_byte_busy;

    modport slave (
        input  req_vec, req_byte_d, req_byte_en, req_byte_done, tx_byte_busy,
        output gnt_vec, req_byte_busy, tx_byte_d, tx_byte_en, tx_byte_done
    );

    modport master (
        output req_vec, req_byte_d, req_byte_en, req_byte_done, tx_byte_busy,
        input  gnt_vec, req_byte_busy, tx_byte_d, tx_byte_en, tx_byte_done
    );

endinterface

// File: rtl/mesa_tx_arbiter_rr_pick.sv
// mesa_rr_pick: combinational round-robin picker. Searches the request
// vector starting just after last_winner (wrapping) and returns the first
// requester as a one-hot vector plus its index. Output is zero if no request.
module mesa_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_winner,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the sources in priority order and take the first one requesting.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the loop leaves a signal unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            sum = {1'b0, last_winner} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mesa_tx_arbiter.sv
// mesa_tx_arbiter: shares one byte->ASCII/UART transmit path between N_REQ
// byte-stream sources with whole-packet round-robin grants. A granted source
// keeps the link until it strobes byte_done, so packets never interleave.
// Optional idle watchdog: define MESA_TX_ARB_TIMEOUT_EN to force end-of-packet
// on a winner that stays silent for a full TIMEOUT_BITS counter span.
module mesa_tx_arbiter
    import mesa_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    mesa_tx_arbiter_if.slave bus,
    output logic             arb_err,
    output logic             arb_timeout
);

    localparam int IDX_W = idx_width(N_REQ);

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("mesa_tx_arbiter: N_REQ out of range");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_gnt;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] busy;
    logic [N_REQ-1:0] accept;
    logic [7:0]       tx_d_q, tx_d_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_done_q, tx_done_d;
    logic             err_d;
    logic             win_en, win_done;
    logic [7:0]       win_byte;
    logic             to_fire;

    mesa_rr_pick #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_pick (
        .req        (bus.req_vec),
        .last_winner(last_q),
        .gnt        (pick_gnt),
        .gnt_idx    (pick_idx)
    );

    // Current winner's strobes and byte.
    assign win_en   = bus.req_byte_en[win_q];
    assign win_done = bus.req_byte_done[win_q];
    assign win_byte = bus.req_byte_d[{win_q, 3'b000} +: 8];

`ifdef MESA_TX_ARB_TIMEOUT_EN
    // The pulse is registered, so fire on the cycle the counter would reach
    // all-ones; the pulse then lands together with the all-ones count.
    localparam logic [TIMEOUT_BITS-1:0] TO_FIRE_AT = ~TIMEOUT_BITS'(1);

    logic [TIMEOUT_BITS-1:0] to_cnt_q;

    assign to_fire = (state_q == ARB_GRANT) && !win_en && !win_done &&
                     (to_cnt_q == TO_FIRE_AT);

    // Idle watchdog: counts silent GRANT cycles, cleared outside GRANT and on each winner byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (state_q != ARB_GRANT || win_en) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TIMEOUT_BITS'(1);
        end
    end

    // One-cycle watchdog pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            arb_timeout <= 1'b0;
        end else begin
            arb_timeout <= to_fire;
        end
    end
`else
    logic [TIMEOUT_BITS-1:0] timeout_unused;

    assign timeout_unused = '0;
    assign to_fire        = 1'b0;
    assign arb_timeout    = 1'b0;
`endif

    // Next-state and registered-output values for the grant FSM.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        tx_d_d    = tx_d_q;
        tx_en_d   = 1'b0;
        tx_done_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|bus.req_vec) begin
                    state_d = ARB_GRANT;
                    win_d   = pick_idx;
                    gnt_d   = pick_gnt;
                end
            end
            ARB_GRANT: begin
                // A dropped req_vec is ignored: only byte_done (or the
                // watchdog) ends the packet.
                if (win_en) begin
                    tx_en_d = 1'b1;
                    tx_d_d  = win_byte;
                end
                if (win_done || to_fire) begin
                    tx_done_d = 1'b1;
                    state_d   = ARB_DRAIN;
                    last_d    = win_q;
                    gnt_d     = '0;
                end
            end
            ARB_DRAIN: begin
                if (!bus.tx_byte_busy && !tx_done_q) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Strobes from anyone but the current winner in GRANT are dropped and flagged.
    always_comb begin
        accept = (state_q == ARB_GRANT) ? gnt_q : '0;
        err_d  = |((bus.req_byte_en | bus.req_byte_done) & ~accept);
    end

    // Only the winner in GRANT may see busy low; tx_en_q covers the pipeline cycle.
    always_comb begin
        busy = '1;
        if (!reset && state_q == ARB_GRANT) begin
            busy[win_q] = bus.tx_byte_busy | tx_en_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= ARB_IDLE;
            win_q     <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            gnt_q     <= '0;
            tx_d_q    <= '0;
            tx_en_q   <= 1'b0;
            tx_done_q <= 1'b0;
            arb_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            tx_d_q    <= tx_d_d;
            tx_en_q   <= tx_en_d;
            tx_done_q <= tx_done_d;
            arb_err   <= err_d;
        end
    end

    assign bus.gnt_vec       = gnt_q;
    assign bus.req_byte_busy = busy;
    assign bus.tx_byte_d     = tx_d_q;
    assign bus.tx_byte_en    = tx_en_q;
    assign bus.tx_byte_done  = tx_done_q;

endmodule

// File: tb/tb_mesa_tx_arbiter.sv
// Self-checking bench for mesa_tx_arbiter (N_REQ=2). Table-driven cycle
// vectors cover single packets, round-robin order, ungranted traffic and
// same-cycle byte+done; hand sequences cover reset mid-packet and the
// stalled winner (watchdog when MESA_TX_ARB_TIMEOUT_EN is defined).
module tb_mesa_tx_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic arb_err;
    logic arb_timeout;

    int total = 0;
    int bad   = 0;
    int leak77 = 0;

    mesa_tx_arbiter_if #(.N_REQ(2)) bus ();

    mesa_tx_arbiter #(
        .N_REQ       (2),
        .TIMEOUT_BITS(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .arb_err    (arb_err),
        .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    // The dropped byte 0x77 must never appear on the converter side.
    always @(negedge clk) begin
        if (bus.tx_byte_en === 1'b1 && bus.tx_byte_d === 8'h77) leak77++;
    end

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  en;
        logic [1:0]  done;
        logic [15:0] d;
        logic        txb;
        logic [1:0]  e_gnt;
        logic        e_en;
        logic [7:0]  e_d;
        logic        e_done;
        logic        e_err;
        logic [1:0]  e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic [1:0] en,
                                input logic [1:0] done, input logic [15:0] d, input logic txb,
                                input logic [1:0] e_gnt, input logic e_en, input logic [7:0] e_d,
                                input logic e_done, input logic e_err, input logic [1:0] e_busy);
        vec_t v;
        v.rst = rst; v.req = req; v.en = en; v.done = done; v.d = d; v.txb = txb;
        v.e_gnt = e_gnt; v.e_en = e_en; v.e_d = e_d; v.e_done = e_done;
        v.e_err = e_err; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic [1:0] req, input logic [1:0] en,
                         input logic [1:0] done, input logic [15:0] d, input logic txb);
        reset             = rst;
        bus.req_vec       = req;
        bus.req_byte_en   = en;
        bus.req_byte_done = done;
        bus.req_byte_d    = d;
        bus.tx_byte_busy  = txb;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int held;
        int fire_at;

        // rst req  en   done  d        txb  gnt  en  d      done err busy
        // Test 1: single packet from source 0
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 16'h0000, 0, 2'b01, 0, 8'h00, 0, 0, 2'b10));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b00, 16'h00A5, 0, 2'b01, 1, 8'hA5, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 16'h0000, 0, 2'b01, 0, 8'h00, 0, 0, 2'b10));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b00, 16'h003C, 0, 2'b01, 1, 8'h3C, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 16'h0000, 0, 2'b01, 0, 8'h00, 0, 0, 2'b10));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b01, 16'h0000, 0, 2'b00, 0, 8'h00, 1, 0, 2'b11));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        // Test 2: both requesting -> grants 0,1,0,1 (third packet is byte+done together)
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b01, 0, 8'h00, 0, 0, 2'b10));
        vecs.push_back(mk(0, 2'b11, 2'b01, 2'b00, 16'h0011, 0, 2'b01, 1, 8'h11, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b01, 16'h0000, 0, 2'b00, 0, 8'h00, 1, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b10, 0, 8'h00, 0, 0, 2'b01));
        vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 16'h2200, 0, 2'b10, 1, 8'h22, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 16'h0000, 0, 2'b00, 0, 8'h00, 1, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b01, 0, 8'h00, 0, 0, 2'b10));
        // Test 4: byte_en + byte_done in the same cycle
        vecs.push_back(mk(0, 2'b11, 2'b01, 2'b01, 16'h000F, 0, 2'b00, 1, 8'h0F, 1, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b10, 0, 8'h00, 0, 0, 2'b01));
        // Test 3: source 0 strobes 0x77 while source 1 holds the grant
        vecs.push_back(mk(0, 2'b11, 2'b01, 2'b00, 16'h0077, 0, 2'b10, 0, 8'h00, 0, 1, 2'b01));
        vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 16'h4400, 0, 2'b10, 1, 8'h44, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 1, 2'b10, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b10, 0, 8'h00, 0, 0, 2'b01));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 16'h0000, 0, 2'b00, 0, 8'h00, 1, 0, 2'b11));
        // DRAIN: traffic dropped, converter busy holds DRAIN
        vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 16'h9900, 1, 2'b00, 0, 8'h00, 0, 1, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 1, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 2'b01, 0, 8'h00, 0, 0, 2'b10));
        // Winner drops req_vec: grant held; ungranted done flagged
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b10, 16'h0000, 0, 2'b01, 0, 8'h00, 0, 1, 2'b10));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 2'b01, 0, 8'h00, 0, 0, 2'b10));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b01, 16'h0000, 0, 2'b00, 0, 8'h00, 1, 0, 2'b11));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 0, 8'h00, 0, 0, 2'b11));
        // IDLE traffic dropped
        vecs.push_back(mk(0, 2'b00, 2'b01, 2'b00, 16'h00EE, 0, 2'b00, 0, 8'h00, 0, 1, 2'b11));

        // Reset state
        drive(1, 2'b00, 2'b00, 2'b00, 16'h0000, 0);
        step();
        step();
        check("rst_gnt", bus.gnt_vec, 2'b00);
        check("rst_tx_en", bus.tx_byte_en, 1'b0);
        check("rst_tx_done", bus.tx_byte_done, 1'b0);
        check("rst_tx_d", bus.tx_byte_d, 8'h00);
        check("rst_err", arb_err, 1'b0);
        check("rst_timeout", arb_timeout, 1'b0);
        check("rst_busy", bus.req_byte_busy, 2'b11);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].en, vecs[i].done, vecs[i].d, vecs[i].txb);
            step();
            check($sformatf("v%0d_gnt", i), bus.gnt_vec, vecs[i].e_gnt);
            check($sformatf("v%0d_tx_en", i), bus.tx_byte_en, vecs[i].e_en);
            if (vecs[i].e_en) check($sformatf("v%0d_tx_d", i), bus.tx_byte_d, vecs[i].e_d);
            check($sformatf("v%0d_tx_done", i), bus.tx_byte_done, vecs[i].e_done);
            check($sformatf("v%0d_err", i), arb_err, vecs[i].e_err);
            check($sformatf("v%0d_busy", i), bus.req_byte_busy, vecs[i].e_busy);
            check($sformatf("v%0d_timeout", i), arb_timeout, 1'b0);
        end

        // Test 5: reset mid-packet (source 1 granted, last winner was 0)
        drive(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0);
        step();
        check("t5_gnt1", bus.gnt_vec, 2'b10);
        drive(0, 2'b11, 2'b10, 2'b00, 16'h5100, 0);
        step();
        check("t5_byte1", bus.tx_byte_d, 8'h51);
        check("t5_en1", bus.tx_byte_en, 1'b1);
        drive(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0);
        step();
        check("t5_busy", bus.req_byte_busy, 2'b01);
        drive(1, 2'b11, 2'b00, 2'b00, 16'h0000, 0);
        step();
        check("t5_rst_gnt", bus.gnt_vec, 2'b00);
        check("t5_rst_done", bus.tx_byte_done, 1'b0);
        check("t5_rst_en", bus.tx_byte_en, 1'b0);
        check("t5_rst_busy", bus.req_byte_busy, 2'b11);
        drive(0, 2'b11, 2'b00, 2'b00, 16'h0000, 0);
        step();
        check("t5_regrant", bus.gnt_vec, 2'b01);
        check("t5_no_done", bus.tx_byte_done, 1'b0);

`ifdef MESA_TX_ARB_TIMEOUT_EN
        // Test 6: source 0 goes silent; watchdog ends its packet
        fire_at = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (arb_timeout === 1'b1) begin
                fire_at = k;
                check("t6_forced_done", bus.tx_byte_done, 1'b1);
                check("t6_gnt_drop", bus.gnt_vec, 2'b00);
                break;
            end
        end
        check("t6_latency", fire_at, 15);
        step();
        check("t6_pulse_1clk", arb_timeout, 1'b0);
        step();
        step();
        check("t6_next_gnt", bus.gnt_vec, 2'b10);
`else
        // Without the watchdog a silent winner keeps the link
        held = 0;
        fire_at = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.gnt_vec === 2'b01 && bus.tx_byte_done === 1'b0) held++;
            if (arb_timeout !== 1'b0) fire_at++;
        end
        check("stall_hold", held, 30);
        check("stall_no_timeout", fire_at, 0);
`endif

        check("no_77_leak", leak77, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
